mem_reg_bank: RTL and testbench
===============================

Name: mem_reg_bank

Overview:
Parametrised flip-flop register bank: DEPTH words of WIDTH bits. It has one synchronous write port and one registered read port with a valid strobe. It also has a sweep-clear engine that zeroes the array one word per cycle. It generalises the single positive-edge flip-flop storage cell into the building block for the mem8x8 array and larger variants. All storage updates on the rising edge of clkPE.

Parameters:
WIDTH, 8, data bits per word (>=1)
DEPTH, 8, number of words (>=2; need not be a power of two)
ADDR_W, 3, address width; must satisfy 2**ADDR_W >= DEPTH

Ports:
clkPE  input  1  clock; all state updates on rising edge
rstN  input  1  asynchronous active-low reset
wrEn  input  1  write request this cycle
wrAddr  input  ADDR_W  write word address
wrData  input  WIDTH  write data
rdEn  input  1  read request this cycle
rdAddr  input  ADDR_W  read word address
rdData  output  WIDTH  registered read data
rdValid  output  1  rdData holds the result of a read accepted last cycle
clr  input  1  start sweep-clear (level-sampled; acted on only in IDLE)
busy  output  1  sweep-clear in progress

Behaviour:
- Reset: one clock (clkPE); reset is asynchronous and active-low (rstN).
  - rstN=0 immediately forces all DEPTH words to 0, rdData=0, rdValid=0, busy=0, state=IDLE, sweep pointer=0.
  - Reset asserted mid-sweep or mid-read aborts the operation with no residual effect.
- State machine: IDLE, CLEAR.
  - IDLE -> CLEAR when clr=1 at a rising edge. Pointer loads 0; busy=1 from the next cycle.
  - CLEAR: each edge writes 0 to word[pointer], then pointer+1.
  - CLEAR -> IDLE on the edge that clears word DEPTH-1. busy=0 on the following cycle.
  - Sweep takes exactly DEPTH cycles. clr during CLEAR is ignored (no restart).
- Write (IDLE only): wrEn=1 and wrAddr<DEPTH -> word[wrAddr]<=wrData at the edge.
  - wrAddr>=DEPTH: write dropped silently.
  - In CLEAR: wrEn ignored.
- Read (IDLE only): rdEn=1 at edge N -> rdData=word[rdAddr] and rdValid=1 after edge N, i.e. 1-cycle latency.
  - rdAddr>=DEPTH: rdData=0, rdValid=1.
  - rdEn=0: rdValid=0 after the edge; rdData holds its last value.
  - In CLEAR: rdEn ignored; rdValid=0.
- Simultaneous read and write to the same address in the same cycle: read-before-write. rdData returns the old word; the new data is visible from the next read.
- Simultaneous clr and wrEn/rdEn in IDLE: the write and read in that cycle are still performed. CLEAR begins the next cycle, so a clr-cycle write is then swept to 0.
- No combinational path from any input to rdData, rdValid or busy.

Optional Feature:
Macro WR_FORWARD_EN.
- Defined: same-address simultaneous read and write returns wrData on rdData (write-first forwarding). Applies only when the write is actually performed (IDLE, wrAddr<DEPTH).
- Undefined: read-before-write as specified above.
- Port list and all other timing identical in both builds.

Test Plan:
1. rstN=0 then release; write 0xA5 to addr 3; read addr 3 next cycle -> rdData=0xA5, rdValid=1 exactly one edge after the read; addr 2 reads 0x00.
2. Write 0x11..0x88 to addrs 0..7 on consecutive edges; read back 0..7 back-to-back -> rdData 0x11..0x88 in order, rdValid continuously 1.
3. Addr 5 holds 0x3C; in one cycle write 0xC3 to addr 5 and read addr 5 -> 0x3C without WR_FORWARD_EN, 0xC3 with it; a following read returns 0xC3 in both builds.
4. Array filled with 0xFF; pulse clr one cycle -> busy=1 for exactly 8 cycles. Writes and reads during busy are ignored and rdValid=0. After busy falls, every address reads 0x00.
5. Assert rstN=0 at sweep cycle 3 while a read is pending -> busy, rdValid and rdData drop to 0 immediately; after release, all words read 0 and IDLE accepts a write on the next edge.
6. DEPTH=6, ADDR_W=3 build: write 0x77 to addr 7 -> no word changes; read addr 7 -> rdData=0, rdValid=1; addr 5 is still writable and readable.

Source files
------------

// File: rtl/mem_reg_bank.sv
// DEPTH x WIDTH flip-flop register bank: one write port, one registered read port,
// and a one-word-per-cycle sweep-clear engine. Optional macro WR_FORWARD_EN.
module mem_reg_bank #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clkPE,
  input  logic              rstN,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [WIDTH-1:0]  wrData,
  input  logic              rdEn,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [WIDTH-1:0]  rdData,
  output logic              rdValid,
  input  logic              clr,
  output logic              busy
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH-1);

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [WIDTH-1:0]  r_rd_data;
  logic              r_rd_valid;
  logic [WIDTH-1:0]  w_rd_word;
  logic              w_idle;
  logic              w_busy;
  logic              w_wr_ok;
  logic              w_rd_ok;
  logic              w_fwd;

  // Handshake: a read accepted at edge N (rdEn=1 in IDLE) presents rdData with
  // rdValid=1 for exactly the cycle after edge N; there is no back-pressure.

  always_ff @(posedge clkPE or negedge rstN) begin
    if (!rstN) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (clr) w_next_state = S_CLEAR;
      S_CLEAR: if (r_ptr == LP_LAST) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_idle = (r_state == S_IDLE);
    w_busy = (r_state == S_CLEAR);
  end

  assign w_wr_ok = w_idle && wrEn && ({1'b0, wrAddr} < LP_DEPTH);
  assign w_rd_ok = w_idle && rdEn;

`ifdef WR_FORWARD_EN
  assign w_fwd = w_wr_ok && (wrAddr == rdAddr);
`else
  assign w_fwd = 1'b0;
`endif

  // Out-of-range reads return zero; forwarding only when the write really lands.
  always_comb begin
    w_rd_word = '0;
    if ({1'b0, rdAddr} < LP_DEPTH) w_rd_word = r_mem[rdAddr];
    if (w_fwd) w_rd_word = wrData;
  end

  // Pointer rests at 0 in IDLE so a new sweep always starts at word 0.
  always_ff @(posedge clkPE or negedge rstN) begin
    if (!rstN)                                      r_ptr <= '0;
    else if (r_state == S_CLEAR && r_ptr != LP_LAST) r_ptr <= r_ptr + 1'b1;
    else                                            r_ptr <= '0;
  end

  always_ff @(posedge clkPE or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (r_state == S_CLEAR) begin
      r_mem[r_ptr] <= '0;
    end else if (w_wr_ok) begin
      r_mem[wrAddr] <= wrData;
    end
  end

  always_ff @(posedge clkPE or negedge rstN) begin
    if (!rstN) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_ok;
      if (w_rd_ok) r_rd_data <= w_rd_word;
    end
  end

  assign rdData  = r_rd_data;
  assign rdValid = r_rd_valid;
  assign busy    = w_busy;

endmodule

// File: tb/tb_mem_reg_bank.sv
// Bench for mem_reg_bank: directed vectors, expected read data queued at issue and
// popped by a monitor whenever rdValid is seen; a DEPTH=6 instance covers holes.
module tb_mem_reg_bank;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       wr_en, rd_en, clr, rd_valid, busy;
  logic [2:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;

  logic       b_wr_en, b_rd_en, b_clr, b_rd_valid, b_busy;
  logic [2:0] b_wr_addr, b_rd_addr;
  logic [7:0] b_wr_data, b_rd_data;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_q6[$];

  mem_reg_bank #(.WIDTH(8), .DEPTH(8), .ADDR_W(3)) dut (
    .clkPE(clk), .rstN(rst_n), .wrEn(wr_en), .wrAddr(wr_addr), .wrData(wr_data),
    .rdEn(rd_en), .rdAddr(rd_addr), .rdData(rd_data), .rdValid(rd_valid),
    .clr(clr), .busy(busy)
  );

  mem_reg_bank #(.WIDTH(8), .DEPTH(6), .ADDR_W(3)) dut6 (
    .clkPE(clk), .rstN(rst_n), .wrEn(b_wr_en), .wrAddr(b_wr_addr), .wrData(b_wr_data),
    .rdEn(b_rd_en), .rdAddr(b_rd_addr), .rdData(b_rd_data), .rdValid(b_rd_valid),
    .clr(b_clr), .busy(b_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rd_valid === 1'b1) begin
      if (exp_q.size() == 0) check("a_unexpected_valid", 32'(1), 32'(0));
      else check("a_rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && b_rd_valid === 1'b1) begin
      if (exp_q6.size() == 0) check("b_unexpected_valid", 32'(1), 32'(0));
      else check("b_rd_data", 32'(b_rd_data), 32'(exp_q6.pop_front()));
    end
  end

  // Driver tasks: inputs apply at the next rising edge, then return to idle.
  task automatic cyc(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                     input logic re, input logic [2:0] ra, input logic c);
    wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra; clr = c;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cyc(1'b1, a, d, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] e);
    exp_q.push_back(e);
    cyc(1'b0, 3'd0, 8'd0, 1'b1, a, 1'b0);
  endtask

  task automatic b_cyc(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                       input logic re, input logic [2:0] ra);
    b_wr_en = we; b_wr_addr = wa; b_wr_data = wd; b_rd_en = re; b_rd_addr = ra;
    @(posedge clk); #1;
    b_wr_en = 1'b0; b_rd_en = 1'b0;
  endtask

  task automatic b_rd(input logic [2:0] a, input logic [7:0] e);
    exp_q6.push_back(e);
    b_cyc(1'b0, 3'd0, 8'd0, 1'b1, a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    wr_en = 0; wr_addr = 0; wr_data = 0; rd_en = 0; rd_addr = 0; clr = 0;
    b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0; b_rd_en = 0; b_rd_addr = 0; b_clr = 0;
    #2;
    check("reset_rd_data", 32'(rd_data), 32'(0));
    check("reset_rd_valid", 32'(rd_valid), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_b_rd_valid", 32'(b_rd_valid), 32'(0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: single write / read with exact latency
    wr(3'd3, 8'hA5);
    check("t1_valid_before_read", 32'(rd_valid), 32'(0));
    rd(3'd3, 8'hA5);
    check("t1_valid_after_edge", 32'(rd_valid), 32'(1));
    check("t1_data_after_edge", 32'(rd_data), 32'hA5);
    rd(3'd2, 8'h00);

    // 2: fill and back-to-back readback
    for (int i = 0; i < 8; i++) wr(3'(i), 8'((i + 1) * 8'h11));
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), 8'((i + 1) * 8'h11));
      check("t2_valid_streaming", 32'(rd_valid), 32'(1));
    end
    cyc(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 1'b0);
    check("t2_idle_valid_low", 32'(rd_valid), 32'(0));
    check("t2_idle_data_holds", 32'(rd_data), 32'h88);

    // 3: same-address read and write
    wr(3'd5, 8'h3C);
`ifdef WR_FORWARD_EN
    exp_q.push_back(8'hC3);
`else
    exp_q.push_back(8'h3C);
`endif
    cyc(1'b1, 3'd5, 8'hC3, 1'b1, 3'd5, 1'b0);
    rd(3'd5, 8'hC3);

    // 4: sweep clear; the clr-cycle write and read still happen
    for (int i = 0; i < 8; i++) wr(3'(i), 8'hFF);
    exp_q.push_back(8'hFF);
    cyc(1'b1, 3'd0, 8'h42, 1'b1, 3'd1, 1'b1);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      if (n > 1) check("t4_valid_low_in_clear", 32'(rd_valid), 32'(0));
      cyc(1'b1, 3'(n), 8'h5A, 1'b1, 3'(n), 1'b1);
    end
    check("t4_busy_cycles", 32'(n), 32'(8));
    check("t4_valid_after_sweep", 32'(rd_valid), 32'(0));
    for (int i = 0; i < 8; i++) rd(3'(i), 8'h00);

    // 5: reset in the middle of a sweep
    for (int i = 0; i < 8; i++) wr(3'(i), 8'(8'h20 + i));
    rd(3'd2, 8'h22);
    cyc(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 3'd0, 8'd0, 1'b1, 3'd6, 1'b0);
    check("t5_busy_mid_sweep", 32'(busy), 32'(1));
    check("t5_data_holds_in_clear", 32'(rd_data), 32'h22);
    rst_n = 1'b0;
    #1;
    check("t5_reset_busy", 32'(busy), 32'(0));
    check("t5_reset_valid", 32'(rd_valid), 32'(0));
    check("t5_reset_data", 32'(rd_data), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    wr(3'd4, 8'h99);
    for (int i = 0; i < 8; i++) rd(3'(i), (i == 4) ? 8'h99 : 8'h00);

    // 6: DEPTH=6 instance, holes in the address space
    for (int i = 0; i < 6; i++) b_cyc(1'b1, 3'(i), 8'(8'h10 + i), 1'b0, 3'd0);
    b_cyc(1'b1, 3'd7, 8'h77, 1'b0, 3'd0);
    b_cyc(1'b1, 3'd6, 8'h66, 1'b0, 3'd0);
    b_rd(3'd7, 8'h00);
    check("t6_hole_read_valid", 32'(b_rd_valid), 32'(1));
    b_rd(3'd6, 8'h00);
    for (int i = 0; i < 6; i++) b_rd(3'(i), 8'(8'h10 + i));
    b_cyc(1'b1, 3'd5, 8'hAB, 1'b0, 3'd0);
    b_rd(3'd5, 8'hAB);

    cyc(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 1'b0);
    cyc(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 1'b0);
    check("a_queue_drained", 32'(exp_q.size()), 32'(0));
    check("b_queue_drained", 32'(exp_q6.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
